sa_write_arbiter: RTL
=====================

// Module: sa_write_arbiter
// PURPOSE
// Per-slave write-side arbitration stage, directly downstream of the per-master dispatchers.
// - AW: round-robin arbitrates the AW requests of MST_AMT dispatchers and registers the winner toward one slave.
// - AWID on the slave side is extended with the master index: {mst_idx, AWID}.
// - W: steers write data from the masters in AW-grant order, one whole burst (up to WLAST) at a time.
// PARAMETERS
// MST_AMT            2   number of masters/dispatchers feeding this slave
// OUTSTANDING_AMT    8   depth of W-order FIFO (max AW granted but W not finished)
// DATA_WIDTH        32   WDATA width
// ADDR_WIDTH        32   AWADDR width
// TRANS_MST_ID_W     5   master transaction ID width
// TRANS_BURST_W      2   AWBURST width
// TRANS_DATA_LEN_W   3   AWLEN width
// TRANS_DATA_SIZE_W  3   AWSIZE width
// MST_ID_W  $clog2(MST_AMT) master index width; TRANS_SLV_ID_W = MST_ID_W+TRANS_MST_ID_W
// PORTS
// ACLK_i              in   1                         clock, all logic on rising edge
// ARESETn_i           in   1                         asynchronous active-low reset
// dsp_AWID_i          in   TRANS_MST_ID_W*MST_AMT    per-master AWID, master k at slice k
// dsp_AWADDR_i        in   ADDR_WIDTH*MST_AMT        per-master AWADDR
// dsp_AWBURST_i       in   TRANS_BURST_W*MST_AMT     per-master AWBURST
// dsp_AWLEN_i         in   TRANS_DATA_LEN_W*MST_AMT  per-master AWLEN
// dsp_AWSIZE_i        in   TRANS_DATA_SIZE_W*MST_AMT per-master AWSIZE
// dsp_AWVALID_i       in   MST_AMT                   per-master AW valid
// dsp_AW_outst_full_i in   MST_AMT                   dispatcher outstanding full; masks that master's request
// dsp_AWREADY_o       out  MST_AMT                   one-hot AW grant/ready
// dsp_WDATA_i         in   DATA_WIDTH*MST_AMT        per-master WDATA
// dsp_WLAST_i         in   MST_AMT                   per-master WLAST
// dsp_WVALID_i        in   MST_AMT                   per-master WVALID
// dsp_WREADY_o        out  MST_AMT                   per-master WREADY, at most one bit high
// s_AWID_o            out  TRANS_SLV_ID_W            {mst_idx, AWID}
// s_AWADDR_o/BURST_o/LEN_o/SIZE_o  out  as above     registered AW payload
// s_AWVALID_o         out  1                         registered AW valid
// s_AWREADY_i         in   1                         slave AW ready
// s_WDATA_o           out  DATA_WIDTH                selected WDATA
// s_WLAST_o           out  1                         selected WLAST
// s_WVALID_o          out  1                         selected WVALID
// s_WREADY_i          in   1                         slave W ready
// BEHAVIOUR
// Reset: s_AWVALID_o=0, AW payload regs=0, RR pointer=0, order FIFO empty; hence dsp_WREADY_o=0, s_WVALID_o=0.
// AW request: req[k] = dsp_AWVALID_i[k] & ~dsp_AW_outst_full_i[k].
// AW slot free: free = ~s_AWVALID_o | s_AWREADY_i.
// AW grant, combinational: if free & ~fifo_full & |req, grant the first req at or after ptr (cyclic).
// - dsp_AWREADY_o = one-hot of grant, else 0.
// - On grant g at a clock edge: AW reg <= master g payload, s_AWID_o <= {g, AWID_g}, s_AWVALID_o <= 1.
// - Same edge: ptr <= (g+1) mod MST_AMT; g pushed to order FIFO.
// - AW latency is 1 cycle; back-to-back grants at full throughput while the slave holds AWREADY high.
// - If s_AWREADY_i=1 and no grant: s_AWVALID_o <= 0. s_AW* held stable while VALID & ~READY (AXI rule).
// W steering (combinational, 0 latency), h = FIFO head:
// - s_WVALID_o = ~empty & dsp_WVALID_i[h]; s_WDATA_o/s_WLAST_o = master h.
// - dsp_WREADY_o[h] = ~empty & s_WREADY_i; all other bits 0.
// - Pop when s_WVALID_o & s_WREADY_i & s_WLAST_o; the next burst may start the following cycle.
// - W from a master whose AW is not yet granted is stalled (WREADY=0), never dropped or reordered.
// Boundaries:
// - FIFO full: no AW grant. A same-cycle push and pop is allowed when full (pop frees a slot first).
// - FIFO empty: push and W are not bypassed; W of a just-granted AW starts the next cycle.
// - Requester drops AWVALID: RR pointer unchanged. Outst_full asserts mid-wait: request masked that cycle.
// - MST_AMT=1: MST_ID_W forced to 1; index bit is 0.
// - Reset asserted mid-burst: all state cleared immediately. In-flight AW/W is lost; upstream resets together.
// STRUCTURE
// Shared package ai_pkg: AXI width localparams, TRANS_SLV_ID_W, burst type constants.
// Sub-module: sa_order_fifo (sync FIFO, WIDTH=MST_ID_W, DEPTH=OUTSTANDING_AMT, full/empty flags).
// RR arbiter and AW register stay inline.
// TESTING
// 1 M0,M1 both AWVALID from reset, AWREADY=1 -> grants M0 then M1 on consecutive cycles; s_AWID_o={0,id0} then {1,id1}.
// 2 AWs M1 (LEN=3) then M0 (LEN=1); M0 W first -> M0 WREADY=0 until M1's 4 beats end with WLAST; then M0's 2 beats.
// 3 s_AWREADY_i=0 for 5 cycles -> s_AW* stable; no further dsp_AWREADY_o; releases 1 cycle after AWREADY=1.
// 4 OUTSTANDING_AMT=2, W stalled -> third AW not granted; WLAST pop in cycle n -> grant in cycle n (same cycle).
// 5 dsp_AW_outst_full_i[0]=1, both valid -> only M1 granted; M0 granted after full drops.
// 6 ARESETn_i low mid-W-burst -> s_AWVALID_o, s_WVALID_o, dsp_WREADY_o = 0 asynchronously; ptr=0 after release.

Source files
------------

// File: rtl/ai_pkg.sv
// Shared AXI write-path constants and helpers for the slave-side arbitration stage.
// Width defaults and burst encodings are reused by every block in the interconnect.
package ai_pkg;

    localparam int AXI_DATA_WIDTH      = 32;
    localparam int AXI_ADDR_WIDTH      = 32;
    localparam int AXI_MST_ID_W        = 5;
    localparam int AXI_BURST_W         = 2;
    localparam int AXI_LEN_W           = 3;
    localparam int AXI_SIZE_W          = 3;

    typedef enum logic [AXI_BURST_W-1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    // A single master still carries one index bit so the slave ID width never collapses to zero.
    function automatic int mst_id_width(input int mst_amt);
        return (mst_amt <= 1) ? 1 : $clog2(mst_amt);
    endfunction

    function automatic int slv_id_width(input int mst_amt, input int mst_id_w);
        return mst_id_width(mst_amt) + mst_id_w;
    endfunction

endpackage

// File: rtl/sa_order_fifo.sv
// Synchronous FIFO recording the AW-grant order so W bursts are steered in the same order.
// The caller only pushes when there is room (or a pop happens in the same cycle).
module sa_order_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; entries are only read after being written, and the empty flag guards them.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/sa_write_arbiter.sv
// Per-slave write arbitration: round-robin AW grant into a registered AW slot,
// and W steering from the masters in AW-grant order, one whole burst at a time.
module sa_write_arbiter
    import ai_pkg::*;
#(
    parameter int MST_AMT           = 2,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int DATA_WIDTH        = AXI_DATA_WIDTH,
    parameter int ADDR_WIDTH        = AXI_ADDR_WIDTH,
    parameter int TRANS_MST_ID_W    = AXI_MST_ID_W,
    parameter int TRANS_BURST_W     = AXI_BURST_W,
    parameter int TRANS_DATA_LEN_W  = AXI_LEN_W,
    parameter int TRANS_DATA_SIZE_W = AXI_SIZE_W,
    localparam int MST_ID_W         = mst_id_width(MST_AMT),
    localparam int TRANS_SLV_ID_W   = slv_id_width(MST_AMT, TRANS_MST_ID_W)
) (
    input  logic                                   ACLK_i,
    input  logic                                   ARESETn_i,
    input  logic [TRANS_MST_ID_W*MST_AMT-1:0]      dsp_AWID_i,
    input  logic [ADDR_WIDTH*MST_AMT-1:0]          dsp_AWADDR_i,
    input  logic [TRANS_BURST_W*MST_AMT-1:0]       dsp_AWBURST_i,
    input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]    dsp_AWLEN_i,
    input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]   dsp_AWSIZE_i,
    input  logic [MST_AMT-1:0]                     dsp_AWVALID_i,
    input  logic [MST_AMT-1:0]                     dsp_AW_outst_full_i,
    output logic [MST_AMT-1:0]                     dsp_AWREADY_o,
    input  logic [DATA_WIDTH*MST_AMT-1:0]          dsp_WDATA_i,
    input  logic [MST_AMT-1:0]                     dsp_WLAST_i,
    input  logic [MST_AMT-1:0]                     dsp_WVALID_i,
    output logic [MST_AMT-1:0]                     dsp_WREADY_o,
    output logic [TRANS_SLV_ID_W-1:0]              s_AWID_o,
    output logic [ADDR_WIDTH-1:0]                  s_AWADDR_o,
    output logic [TRANS_BURST_W-1:0]               s_AWBURST_o,
    output logic [TRANS_DATA_LEN_W-1:0]            s_AWLEN_o,
    output logic [TRANS_DATA_SIZE_W-1:0]           s_AWSIZE_o,
    output logic                                   s_AWVALID_o,
    input  logic                                   s_AWREADY_i,
    output logic [DATA_WIDTH-1:0]                  s_WDATA_o,
    output logic                                   s_WLAST_o,
    output logic                                   s_WVALID_o,
    input  logic                                   s_WREADY_i
);

    logic [TRANS_MST_ID_W-1:0]    aw_id   [MST_AMT];
    logic [ADDR_WIDTH-1:0]        aw_addr [MST_AMT];
    logic [TRANS_BURST_W-1:0]     aw_burst[MST_AMT];
    logic [TRANS_DATA_LEN_W-1:0]  aw_len  [MST_AMT];
    logic [TRANS_DATA_SIZE_W-1:0] aw_size [MST_AMT];
    logic [DATA_WIDTH-1:0]        w_data  [MST_AMT];

    for (genvar k = 0; k < MST_AMT; k++) begin : g_unpack
        assign aw_id[k]    = dsp_AWID_i   [k*TRANS_MST_ID_W    +: TRANS_MST_ID_W];
        assign aw_addr[k]  = dsp_AWADDR_i [k*ADDR_WIDTH        +: ADDR_WIDTH];
        assign aw_burst[k] = dsp_AWBURST_i[k*TRANS_BURST_W     +: TRANS_BURST_W];
        assign aw_len[k]   = dsp_AWLEN_i  [k*TRANS_DATA_LEN_W  +: TRANS_DATA_LEN_W];
        assign aw_size[k]  = dsp_AWSIZE_i [k*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
        assign w_data[k]   = dsp_WDATA_i  [k*DATA_WIDTH        +: DATA_WIDTH];
    end

    logic [MST_AMT-1:0]  aw_req;
    logic                aw_free;
    logic                aw_found;
    logic                aw_grant;
    logic [MST_ID_W-1:0] gnt_idx;
    logic [MST_ID_W-1:0] rr_ptr;
    logic [MST_ID_W-1:0] w_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_room;
    logic                w_pop;

    assign aw_req  = dsp_AWVALID_i & ~dsp_AW_outst_full_i;
    assign aw_free = ~s_AWVALID_o | s_AWREADY_i;

    // A finishing burst frees its order slot in the same cycle, so a full FIFO can still accept a grant.
    assign w_pop     = s_WVALID_o & s_WREADY_i & s_WLAST_o;
    assign fifo_room = ~fifo_full | w_pop;
    assign aw_grant  = aw_free & fifo_room & aw_found;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        int idx;
        aw_found = 1'b0;
        gnt_idx  = '0;
        idx      = 0;
        for (int i = 0; i < MST_AMT; i++) begin
            idx = (int'(rr_ptr) + i) % MST_AMT;
            if (!aw_found && aw_req[idx]) begin
                aw_found = 1'b1;
                gnt_idx  = MST_ID_W'(idx);
            end
        end
    end

    always_comb begin
        dsp_AWREADY_o = '0;
        if (aw_grant) dsp_AWREADY_o[gnt_idx] = 1'b1;
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            s_AWVALID_o <= 1'b0;
            s_AWID_o    <= '0;
            s_AWADDR_o  <= '0;
            s_AWBURST_o <= '0;
            s_AWLEN_o   <= '0;
            s_AWSIZE_o  <= '0;
            rr_ptr      <= '0;
        end else if (aw_grant) begin
            s_AWVALID_o <= 1'b1;
            s_AWID_o    <= {gnt_idx, aw_id[gnt_idx]};
            s_AWADDR_o  <= aw_addr[gnt_idx];
            s_AWBURST_o <= aw_burst[gnt_idx];
            s_AWLEN_o   <= aw_len[gnt_idx];
            s_AWSIZE_o  <= aw_size[gnt_idx];
            rr_ptr      <= (gnt_idx == MST_ID_W'(MST_AMT - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (s_AWREADY_i) begin
            s_AWVALID_o <= 1'b0;
        end
    end

    sa_order_fifo #(
        .WIDTH (MST_ID_W),
        .DEPTH (OUTSTANDING_AMT)
    ) u_order_fifo (
        .clk     (ACLK_i),
        .rst_n   (ARESETn_i),
        .push    (aw_grant),
        .wr_data (gnt_idx),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // W follows the oldest granted AW; other masters see WREADY low and simply wait.
    assign s_WVALID_o = ~fifo_empty & dsp_WVALID_i[w_head];
    assign s_WDATA_o  = w_data[w_head];
    assign s_WLAST_o  = dsp_WLAST_i[w_head];

    always_comb begin
        dsp_WREADY_o = '0;
        if (!fifo_empty) dsp_WREADY_o[w_head] = s_WREADY_i;
    end

endmodule
